// File: rtl/decode_stage_hz_if.sv
// rtl/decode_stage_hz_if.sv - Decode-stage bundle: IF/ID inputs, WB/EX/MEM feedback, hazard/branch and ID/EX outputs
//
// Purpose : groups every decode-stage signal except clk/rst into one interface.
// Modports: master - pipeline side (drives i_*, observes o_*)
//           slave  - decode stage (observes i_*, drives o_*)
// Signals : i_instruction/i_pc/i_valid (IF/ID), i_stall_ext, WB write port
//           (i_write_enable/i_w_dir/i_w_data), EX feedback (i_rd_ex/i_wr_ex/
//           i_memrd_ex/i_data_ex), MEM feedback (i_rd_mem/i_wr_mem/i_data_mem),
//           combinational o_stall_if/o_flush_if/o_branch_taken/o_branch_target,
//           registered ID/EX fields and o_registers_debug.
interface decode_stage_hz_if #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int SIZE_OP       = 6
);
  localparam int SIZE_REG_DIR = $clog2(NUM_REGISTERS);

  logic [SIZE-1:0]               i_instruction;
  logic [SIZE-1:0]               i_pc;
  logic                          i_valid;
  logic                          i_stall_ext;
  logic                          i_write_enable;
  logic [SIZE_REG_DIR-1:0]       i_w_dir;
  logic [SIZE-1:0]               i_w_data;
  logic [SIZE_REG_DIR-1:0]       i_rd_ex;
  logic                          i_wr_ex;
  logic                          i_memrd_ex;
  logic [SIZE-1:0]               i_data_ex;
  logic [SIZE_REG_DIR-1:0]       i_rd_mem;
  logic                          i_wr_mem;
  logic [SIZE-1:0]               i_data_mem;

  logic                          o_stall_if;
  logic                          o_flush_if;
  logic                          o_branch_taken;
  logic [SIZE-1:0]               o_branch_target;
  logic                          o_valid;
  logic [SIZE_OP-1:0]            o_op;
  logic [SIZE-1:0]               o_reg_A;
  logic [SIZE-1:0]               o_reg_B;
  logic [SIZE-1:0]               o_immediate;
  logic [SIZE_REG_DIR-1:0]       o_dir_rs;
  logic [SIZE_REG_DIR-1:0]       o_dir_rt;
  logic [SIZE_REG_DIR-1:0]       o_dir_rd;
  logic [SIZE-1:0]               o_pc;
  logic [SIZE*NUM_REGISTERS-1:0] o_registers_debug;

  modport master (
    output i_instruction, i_pc, i_valid, i_stall_ext,
           i_write_enable, i_w_dir, i_w_data,
           i_rd_ex, i_wr_ex, i_memrd_ex, i_data_ex,
           i_rd_mem, i_wr_mem, i_data_mem,
    input  o_stall_if, o_flush_if, o_branch_taken, o_branch_target,
           o_valid, o_op, o_reg_A, o_reg_B, o_immediate,
           o_dir_rs, o_dir_rt, o_dir_rd, o_pc, o_registers_debug
  );

  modport slave (
    input  i_instruction, i_pc, i_valid, i_stall_ext,
           i_write_enable, i_w_dir, i_w_data,
           i_rd_ex, i_wr_ex, i_memrd_ex, i_data_ex,
           i_rd_mem, i_wr_mem, i_data_mem,
    output o_stall_if, o_flush_if, o_branch_taken, o_branch_target,
           o_valid, o_op, o_reg_A, o_reg_B, o_immediate,
           o_dir_rs, o_dir_rt, o_dir_rd, o_pc, o_registers_debug
  );
endinterface

// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - Pipeline decode stage with register file, forwarding, load-use stall and ID branch resolution
//
// Purpose: decodes the IF/ID instruction, reads/forwards operands, detects
//          load-use hazards, resolves BEQ/BNE/J in ID and registers ID/EX.
// Ports  : clk - rising-edge clock
//          rst - asynchronous active-low reset
//          bus - decode_stage_hz_if slave modport (all data/control signals)
module decode_stage_hz #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int SIZE_OP       = 6
) (
  input  logic             clk,
  input  logic             rst,
  decode_stage_hz_if.slave bus
);
  localparam int SIZE_REG_DIR = $clog2(NUM_REGISTERS);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic [SIZE-1:0] rf [NUM_REGISTERS];

  // Instruction fields
  logic [5:0]              op_raw;
  logic [SIZE_OP-1:0]      op;
  logic [SIZE_REG_DIR-1:0] rs, rt, rd;
  logic [SIZE-1:0]         imm;

  assign op_raw = bus.i_instruction[31:26];
  assign op     = SIZE_OP'(bus.i_instruction[31:26]);
  assign rs     = SIZE_REG_DIR'(bus.i_instruction[25:21]);
  assign rt     = SIZE_REG_DIR'(bus.i_instruction[20:16]);
  assign rd     = SIZE_REG_DIR'(bus.i_instruction[15:11]);
  assign imm    = {{(SIZE-16){bus.i_instruction[15]}}, bus.i_instruction[15:0]};

  // Operand read: register 0 is hardwired, then EX (only when its result is
  // already computed, i.e. not a load) beats MEM beats the register file,
  // whose read sees a same-cycle WB write.
  logic [SIZE-1:0] val_a, val_b;

  always_comb begin
    val_a = rf[rs];
    if (bus.i_write_enable && bus.i_w_dir == rs) val_a = bus.i_w_data;
    if (bus.i_wr_mem && bus.i_rd_mem == rs) val_a = bus.i_data_mem;
    if (bus.i_wr_ex && !bus.i_memrd_ex && bus.i_rd_ex == rs) val_a = bus.i_data_ex;
    if (rs == '0) val_a = '0;

    val_b = rf[rt];
    if (bus.i_write_enable && bus.i_w_dir == rt) val_b = bus.i_w_data;
    if (bus.i_wr_mem && bus.i_rd_mem == rt) val_b = bus.i_data_mem;
    if (bus.i_wr_ex && !bus.i_memrd_ex && bus.i_rd_ex == rt) val_b = bus.i_data_ex;
    if (rt == '0) val_b = '0;
  end

  // A load still in EX has no data to forward, so its consumer must wait.
  logic hazard;
  assign hazard = bus.i_valid && bus.i_memrd_ex && bus.i_wr_ex && (bus.i_rd_ex != '0)
                  && ((bus.i_rd_ex == rs) || (bus.i_rd_ex == rt));

  // Branch resolution; held off whenever the instruction cannot advance.
  logic [SIZE-1:0] pc_plus1;
  logic            resolve;
  logic            taken;
  logic [SIZE-1:0] target;

  assign pc_plus1 = bus.i_pc + SIZE'(1);
  assign resolve  = bus.i_valid && !hazard && !bus.i_stall_ext;

  always_comb begin
    taken  = 1'b0;
    target = '0;
    if (resolve) begin
      unique case (op_raw)
        OP_BEQ: begin
          taken  = (val_a == val_b);
          target = pc_plus1 + imm;
        end
        OP_BNE: begin
          taken  = (val_a != val_b);
          target = pc_plus1 + imm;
        end
        OP_J: begin
          taken  = 1'b1;
          target = {pc_plus1[SIZE-1:26], bus.i_instruction[25:0]};
        end
        default: ;
      endcase
    end
    if (!taken) target = '0;
  end

  // During reset every output reads 0, including the combinational ones.
  assign bus.o_stall_if      = rst && (bus.i_stall_ext || hazard);
  assign bus.o_branch_taken  = rst && taken;
  assign bus.o_flush_if      = rst && taken;
  assign bus.o_branch_target = rst ? target : '0;

  // Register file: WB writes are never stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGISTERS; i++) rf[i] <= '0;
    end else if (bus.i_write_enable && bus.i_w_dir != '0) begin
      rf[bus.i_w_dir] <= bus.i_w_data;
    end
  end

  always_comb begin
    bus.o_registers_debug = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) bus.o_registers_debug[SIZE*i +: SIZE] = rf[i];
  end

  // ID/EX register: external stall holds, hazard inserts a bubble, else load.
  logic                    valid_q;
  logic [SIZE_OP-1:0]      op_q;
  logic [SIZE-1:0]         a_q, b_q, imm_q, pc_q;
  logic [SIZE_REG_DIR-1:0] rs_q, rt_q, rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else if (bus.i_stall_ext) begin
      valid_q <= valid_q;
    end else if (hazard) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= bus.i_valid;
      op_q    <= op;
      a_q     <= val_a;
      b_q     <= val_b;
      imm_q   <= imm;
      rs_q    <= rs;
      rt_q    <= rt;
      rd_q    <= rd;
      pc_q    <= bus.i_pc;
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_op        = op_q;
  assign bus.o_reg_A     = a_q;
  assign bus.o_reg_B     = b_q;
  assign bus.o_immediate = imm_q;
  assign bus.o_dir_rs    = rs_q;
  assign bus.o_dir_rt    = rt_q;
  assign bus.o_dir_rd    = rd_q;
  assign bus.o_pc        = pc_q;
endmodule

// File: tb/tb_decode_stage_hz.sv
// tb/tb_decode_stage_hz.sv - Self-checking bench for decode_stage_hz
module tb_decode_stage_hz;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_hz_if #(.SIZE(32), .NUM_REGISTERS(32), .SIZE_OP(6)) bus ();

  decode_stage_hz #(.SIZE(32), .NUM_REGISTERS(32), .SIZE_OP(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        sx;
    logic        we;
    logic [4:0]  w_dir;
    logic [31:0] w_data;
    logic [4:0]  rd_ex;
    logic        wr_ex;
    logic        memrd_ex;
    logic [31:0] data_ex;
    logic [4:0]  rd_mem;
    logic        wr_mem;
    logic [31:0] data_mem;
    logic        e_stall;
    logic        e_taken;
    logic [31:0] e_target;
    logic        e_v;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_imm;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_instruction  = v.instr;
    bus.i_pc           = v.pc;
    bus.i_valid        = v.valid;
    bus.i_stall_ext    = v.sx;
    bus.i_write_enable = v.we;
    bus.i_w_dir        = v.w_dir;
    bus.i_w_data       = v.w_data;
    bus.i_rd_ex        = v.rd_ex;
    bus.i_wr_ex        = v.wr_ex;
    bus.i_memrd_ex     = v.memrd_ex;
    bus.i_data_ex      = v.data_ex;
    bus.i_rd_mem       = v.rd_mem;
    bus.i_wr_mem       = v.wr_mem;
    bus.i_data_mem     = v.data_mem;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //        instr                    pc     vl sx we wd wdata        rdex wr ld dex     rdm wm dmem    st tk target        v  a         b         imm
    tbl[0]  = '{ins(0,5,0,16'h0),      32'h0,   1, 0, 1, 5, 32'h1234,  0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h1234, 32'h0,    32'h0};
    tbl[1]  = '{ins(0,1,5,16'h0),      32'h0,   1, 0, 1, 1, 32'h9,     0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h9,    32'h1234, 32'h0};
    tbl[2]  = '{ins(4,1,2,16'hFFFE),   32'h10,  1, 0, 1, 2, 32'h9,     0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 1, 32'h0F,       1, 32'h9,    32'h9,    32'hFFFFFFFE};
    tbl[3]  = '{ins(5,1,2,16'hFFFE),   32'h10,  1, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h9,    32'h9,    32'hFFFFFFFE};
    tbl[4]  = '{ins(0,3,3,16'h0),      32'h0,   1, 0, 0, 0, 32'h0,     3, 1, 0, 32'hAA, 3, 1, 32'hBB, 0, 0, 32'h0,        1, 32'hAA,   32'hAA,   32'h0};
    tbl[5]  = '{ins(0,0,3,16'h0),      32'h0,   1, 0, 0, 0, 32'h0,     0, 1, 0, 32'h77, 3, 1, 32'hBB, 0, 0, 32'h0,        1, 32'h0,    32'hBB,   32'h0};
    tbl[6]  = '{32'h0800_0123,         32'h40,  1, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 1, 32'h123,      1, 32'h0,    32'h0,    32'h123};
    tbl[7]  = '{32'h0800_0123,         32'h40,  0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h0,    32'h0,    32'h123};
    tbl[8]  = '{ins(0,0,0,16'h0),      32'h0,   1, 0, 1, 0, 32'hDEAD,  0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h0,    32'h0,    32'h0};
    tbl[9]  = '{ins(4,4,1,16'h5),      32'h20,  1, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4, 1, 32'h9,  0, 1, 32'h26,       1, 32'h9,    32'h9,    32'h5};
    tbl[10] = '{ins(0,0,7,16'h0),      32'h0,   1, 0, 0, 0, 32'h0,     7, 1, 1, 32'h99, 0, 0, 32'h0,  1, 0, 32'h0,        0, 32'h0,    32'h0,    32'h0};
    tbl[11] = '{ins(4,7,7,16'h3),      32'h0,   1, 0, 0, 0, 32'h0,     7, 1, 1, 32'h99, 0, 0, 32'h0,  1, 0, 32'h0,        0, 32'h0,    32'h0,    32'h0};
    tbl[12] = '{ins(0,0,7,16'h0),      32'h0,   0, 0, 0, 0, 32'h0,     7, 1, 1, 32'h99, 7, 1, 32'h42, 0, 0, 32'h0,        0, 32'h0,    32'h42,   32'h0};
    tbl[13] = '{ins(0,0,0,16'h0),      32'h0,   1, 0, 0, 0, 32'h0,     0, 1, 1, 32'h99, 0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h0,    32'h0,    32'h0};
    tbl[14] = '{ins(5,1,5,16'h8000),   32'h100, 1, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 1, 32'hFFFF8101, 1, 32'h9,    32'h1234, 32'hFFFF8000};
    tbl[15] = '{ins(0,1,0,16'h0),      32'h0,   1, 0, 0, 0, 32'h0,     1, 0, 0, 32'h5,  0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h9,    32'h0,    32'h0};

    v = '{default: '0};
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(bus.o_valid), 32'h0);
    check("reset_reg_A", bus.o_reg_A, 32'h0);
    check("reset_debug_x5", bus.o_registers_debug[5*32 +: 32], 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("v%0d_stall", i), 32'(bus.o_stall_if), 32'(tbl[i].e_stall));
      check($sformatf("v%0d_taken", i), 32'(bus.o_branch_taken), 32'(tbl[i].e_taken));
      check($sformatf("v%0d_flush", i), 32'(bus.o_flush_if), 32'(tbl[i].e_taken));
      check($sformatf("v%0d_target", i), bus.o_branch_target, tbl[i].e_target);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].e_v));
      check($sformatf("v%0d_reg_A", i), bus.o_reg_A, tbl[i].e_a);
      check($sformatf("v%0d_reg_B", i), bus.o_reg_B, tbl[i].e_b);
      check($sformatf("v%0d_imm", i), bus.o_immediate, tbl[i].e_imm);
    end
    check("x0_never_written", bus.o_registers_debug[31:0], 32'h0);
    check("x2_written", bus.o_registers_debug[2*32 +: 32], 32'h9);

    // Load-use: stall + bubble, then the load's data arrives from MEM.
    v = '{default: '0};
    v.instr = ins(0, 0, 7, 16'h0); v.valid = 1'b1;
    v.rd_ex = 5'd7; v.wr_ex = 1'b1; v.memrd_ex = 1'b1; v.data_ex = 32'hEE;
    drive(v);
    #1;
    check("lu_stall", 32'(bus.o_stall_if), 32'h1);
    @(posedge clk);
    #1;
    check("lu_bubble_valid", 32'(bus.o_valid), 32'h0);
    v.rd_ex = 5'd0; v.wr_ex = 1'b0; v.memrd_ex = 1'b0;
    v.rd_mem = 5'd7; v.wr_mem = 1'b1; v.data_mem = 32'h55;
    drive(v);
    #1;
    check("lu_release_stall", 32'(bus.o_stall_if), 32'h0);
    @(posedge clk);
    #1;
    check("lu_reg_B", bus.o_reg_B, 32'h55);
    check("lu_valid", 32'(bus.o_valid), 32'h1);

    // External stall: ID/EX frozen, no branch, WB writes still land.
    for (int k = 0; k < 3; k++) begin
      v = '{default: '0};
      v.instr = ins(4, 1, 2, 16'(k + 1)); v.valid = 1'b1; v.sx = 1'b1;
      v.we = 1'b1; v.w_dir = 5'd10; v.w_data = 32'hC0 + 32'(k);
      drive(v);
      #1;
      check($sformatf("sx%0d_stall", k), 32'(bus.o_stall_if), 32'h1);
      check($sformatf("sx%0d_taken", k), 32'(bus.o_branch_taken), 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("sx%0d_reg_B", k), bus.o_reg_B, 32'h55);
      check($sformatf("sx%0d_dir_rt", k), 32'(bus.o_dir_rt), 32'h7);
      check($sformatf("sx%0d_op", k), 32'(bus.o_op), 32'h0);
      check($sformatf("sx%0d_valid", k), 32'(bus.o_valid), 32'h1);
    end
    check("sx_wb_landed", bus.o_registers_debug[10*32 +: 32], 32'hC2);
    v = '{default: '0};
    v.instr = ins(0, 10, 0, 16'h0); v.valid = 1'b1; v.pc = 32'h77;
    drive(v);
    @(posedge clk);
    #1;
    check("sx_after_reg_A", bus.o_reg_A, 32'hC2);
    check("sx_after_pc", bus.o_pc, 32'h77);
    check("sx_after_dir_rs", 32'(bus.o_dir_rs), 32'hA);

    // Reset pulsed between edges while a hazard is present.
    v = '{default: '0};
    v.instr = ins(0, 0, 7, 16'h0); v.valid = 1'b1;
    v.rd_ex = 5'd7; v.wr_ex = 1'b1; v.memrd_ex = 1'b1;
    drive(v);
    #1;
    check("rp_stall_before", 32'(bus.o_stall_if), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rp_valid", 32'(bus.o_valid), 32'h0);
    check("rp_reg_A", bus.o_reg_A, 32'h0);
    check("rp_pc", bus.o_pc, 32'h0);
    check("rp_debug_x10", bus.o_registers_debug[10*32 +: 32], 32'h0);
    check("rp_stall_in_reset", 32'(bus.o_stall_if), 32'h0);
    #1 rst = 1'b1;
    #1;
    check("rp_stall_after", 32'(bus.o_stall_if), 32'h1);
    @(posedge clk);
    #1;
    check("rp_bubble", 32'(bus.o_valid), 32'h0);
    v = '{default: '0};
    v.instr = ins(0, 10, 0, 16'h0); v.valid = 1'b1;
    drive(v);
    @(posedge clk);
    #1;
    check("rp_load_valid", 32'(bus.o_valid), 32'h1);
    check("rp_load_reg_A", bus.o_reg_A, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
